vscale_regfile_wb: RTL

Write-port arbiter and staging buffer placed directly upstream of the integer register file. Each cycle it merges the always-accepted pipeline writeback with results from the multi-cycle multiply/divide unit, which arrive through a valid/ready handshake and wait in a small FIFO. At most one write per cycle goes to the register file's single write port, through an output register. A bypass path lets the decode stage see values that are staged or queued but not yet written to the array.

---
 rtl/vscale_regfile_wb_if.sv | 37 +++
 rtl/vscale_regfile_wb.sv | 128 ++++++++++++
 2 files changed

// File: rtl/vscale_regfile_wb_if.sv
// Bundle of writeback, multiply/divide handshake, register-file write and bypass
// signals for vscale_regfile_wb; slave = the arbiter, master = its environment.
interface vscale_regfile_wb_if #(
    parameter int MD_DEPTH = 2
);
    localparam int PW = $clog2(MD_DEPTH) + 1;

    logic          pipe_wen;
    logic [4:0]    pipe_wa;
    logic [31:0]   pipe_wd;
    logic          md_valid;
    logic          md_ready;
    logic [4:0]    md_wa;
    logic [31:0]   md_wd;
    logic          rf_wen;
    logic [4:0]    rf_wa;
    logic [31:0]   rf_wd;
    logic [4:0]    ra1;
    logic [4:0]    ra2;
    logic          byp1_hit;
    logic          byp2_hit;
    logic [31:0]   byp1_data;
    logic [31:0]   byp2_data;
    logic [PW-1:0] md_pending;

    modport slave (
        input  pipe_wen, pipe_wa, pipe_wd, md_valid, md_wa, md_wd, ra1, ra2,
        output md_ready, rf_wen, rf_wa, rf_wd, byp1_hit, byp2_hit,
               byp1_data, byp2_data, md_pending
    );

    modport master (
        output pipe_wen, pipe_wa, pipe_wd, md_valid, md_wa, md_wd, ra1, ra2,
        input  md_ready, rf_wen, rf_wa, rf_wd, byp1_hit, byp2_hit,
               byp1_data, byp2_data, md_pending
    );
endinterface

// File: rtl/vscale_regfile_wb.sv
// Register-file write-port arbiter: pipeline writeback wins, MD results queue in a FIFO.
// Define VSCALE_WB_BYPASS_EN to build the decode bypass comparators.
module vscale_regfile_wb #(
    parameter int MD_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    vscale_regfile_wb_if.slave  bus
);
    localparam int AW = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
    localparam int PW = $clog2(MD_DEPTH) + 1;

    logic [4:0]          r_wa [MD_DEPTH];
    logic [31:0]         r_wd [MD_DEPTH];
    logic [MD_DEPTH-1:0] r_live;
    logic [PW-1:0]       r_wp;
    logic [PW-1:0]       r_rp;
    logic                r_rf_wen;
    logic [4:0]          r_rf_wa;
    logic [31:0]         r_rf_wd;

    logic [AW-1:0]       w_widx;
    logic [AW-1:0]       w_ridx;
    logic                w_full;
    logic                w_empty;
    logic                w_pipe_stg;
    logic                w_md_acc;
    logic                w_enq;
    logic                w_deq;
    logic                w_fifo_stg;
    logic [PW-1:0]       w_pending;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_widx  = AW'(r_wp % MD_DEPTH);
    assign w_ridx  = AW'(r_rp % MD_DEPTH);
    assign w_empty = (r_wp == r_rp);
    assign w_full  = ((r_wp - r_rp) == PW'(MD_DEPTH));

    assign bus.md_ready = reset_n && !w_full;

    assign w_pipe_stg = bus.pipe_wen && (bus.pipe_wa != 5'd0);
    assign w_md_acc   = bus.md_valid && bus.md_ready;
    // An MD result aimed at the register the pipeline writes this cycle is already stale.
    assign w_enq      = w_md_acc && (bus.md_wa != 5'd0) &&
                        !(w_pipe_stg && (bus.md_wa == bus.pipe_wa));
    assign w_fifo_stg = !w_pipe_stg && !w_empty && r_live[w_ridx];
    // Squashed heads drain even while the pipeline owns the write port.
    assign w_deq      = !w_empty && (!r_live[w_ridx] || !w_pipe_stg);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_live   <= '0;
            r_rf_wen <= 1'b0;
            r_rf_wa  <= 5'd0;
            r_rf_wd  <= 32'd0;
        end else begin
            r_rf_wen <= w_pipe_stg || w_fifo_stg;
            if (w_pipe_stg) begin
                r_rf_wa <= bus.pipe_wa;
                r_rf_wd <= bus.pipe_wd;
            end else if (w_fifo_stg) begin
                r_rf_wa <= r_wa[w_ridx];
                r_rf_wd <= r_wd[w_ridx];
            end
            for (int i = 0; i < MD_DEPTH; i++) begin
                if (w_pipe_stg && (r_wa[i] == bus.pipe_wa))
                    r_live[i] <= 1'b0;
            end
            if (w_deq) begin
                r_live[w_ridx] <= 1'b0;
                r_rp           <= r_rp + 1'b1;
            end
            if (w_enq) begin
                r_live[w_widx] <= 1'b1;
                r_wp           <= r_wp + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_wa[w_widx] <= bus.md_wa;
            r_wd[w_widx] <= bus.md_wd;
        end
    end

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < MD_DEPTH; i++)
            w_pending = w_pending + PW'(r_live[i]);
    end

    assign bus.md_pending = w_pending;
    assign bus.rf_wen     = r_rf_wen;
    assign bus.rf_wa      = r_rf_wa;
    assign bus.rf_wd      = r_rf_wd;

`ifdef VSCALE_WB_BYPASS_EN
    // Walk oldest to youngest from the read pointer so the youngest match lands last.
    function automatic logic [32:0] byp_lookup(input logic [4:0] ra);
        logic [32:0]   res;
        logic [AW-1:0] idx;
        res = 33'd0;
        if (ra != 5'd0) begin
            if (r_rf_wen && (r_rf_wa == ra))
                res = {1'b1, r_rf_wd};
            for (int k = 0; k < MD_DEPTH; k++) begin
                idx = AW'((r_rp + PW'(k)) % MD_DEPTH);
                if (r_live[idx] && (r_wa[idx] == ra))
                    res = {1'b1, r_wd[idx]};
            end
        end
        return res;
    endfunction

    always_comb begin
        {bus.byp1_hit, bus.byp1_data} = byp_lookup(bus.ra1);
        {bus.byp2_hit, bus.byp2_data} = byp_lookup(bus.ra2);
    end
`else
    assign bus.byp1_hit  = 1'b0;
    assign bus.byp2_hit  = 1'b0;
    assign bus.byp1_data = 32'd0;
    assign bus.byp2_data = 32'd0;
`endif
endmodule
